// File: rtl/queue_controller.sv
// First-word-fall-through FIFO controller driving an external 32x32 memory with a
// registered read port; the successor word is prefetched on the edge a pop retires.
module queue_controller #(
    parameter int unsigned ALMOST_FULL_LEVEL = 28
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        pushValid,
    input  logic [31:0] pushData,
    output logic        pushReady,
    output logic        popValid,
    output logic [31:0] popData,
    input  logic        popReady,
    output logic [5:0]  fillLevel,
    output logic        almostFull,
    output logic        memWriteEnable,
    output logic [4:0]  memWriteAddress,
    output logic [31:0] memWriteData,
    output logic [4:0]  memReadAddress,
    input  logic [31:0] memReadData
);

    localparam logic [5:0] Depth   = 6'd32;
    localparam logic [5:0] AfLevel = 6'(ALMOST_FULL_LEVEL);

    logic [4:0] tailPtr;
    logic [4:0] headPtr;
    logic [5:0] count;
    logic       dataValid;
    logic       push;
    logic       pop;

    always_comb begin
        pushReady       = (count != Depth);
        popValid        = dataValid;
        popData         = memReadData;
        push            = pushValid & pushReady;
        pop             = popValid & popReady;
        fillLevel       = count;
        almostFull      = (count >= AfLevel);
        memWriteEnable  = push;
        memWriteAddress = tailPtr;
        memWriteData    = pushData;
        // Present the next head so the memory fetches it on the same edge the pop retires.
        memReadAddress  = pop ? headPtr + 5'd1 : headPtr;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            tailPtr   <= 5'd0;
            headPtr   <= 5'd0;
            count     <= 6'd0;
            dataValid <= 1'b0;
        end else begin
            tailPtr   <= tailPtr + 5'(push);
            headPtr   <= headPtr + 5'(pop);
            count     <= count + 6'(push) - 6'(pop);
            // A word written this edge is not yet readable: same-address read returns old data.
            dataValid <= (count - 6'(pop)) != 6'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (count <= Depth);
        end
    end

endmodule

// File: tb/tb_queue_controller.sv
// Self-checking bench for queue_controller: directed scenarios plus randomized traffic
// checked against a queue-based model tracking the edge at which each word was stored.
module tb_queue_controller;

    logic        clock = 1'b0;
    logic        reset, flush, pushValid, popReady;
    logic [31:0] pushData;
    logic        pushReady, popValid, almostFull, memWriteEnable;
    logic [31:0] popData, memWriteData, memReadData;
    logic [5:0]  fillLevel;
    logic [4:0]  memWriteAddress, memReadAddress;
    logic [31:0] mem [32];

    int total = 0;
    int bad   = 0;

    // Model: stored words plus the edge number at which each was written.
    logic [31:0] md [$];
    int          me [$];
    int          edge_n = 0;
    int          wr_n   = 0;
    int          rd_n   = 0;

    always #5 clock = ~clock;

    queue_controller #(.ALMOST_FULL_LEVEL(28)) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .pushValid       (pushValid),
        .pushData        (pushData),
        .pushReady       (pushReady),
        .popValid        (popValid),
        .popData         (popData),
        .popReady        (popReady),
        .fillLevel       (fillLevel),
        .almostFull      (almostFull),
        .memWriteEnable  (memWriteEnable),
        .memWriteAddress (memWriteAddress),
        .memWriteData    (memWriteData),
        .memReadAddress  (memReadAddress),
        .memReadData     (memReadData)
    );

    always_ff @(posedge clock) begin
        if (memWriteEnable) mem[memWriteAddress] <= memWriteData;
        memReadData <= mem[memReadAddress];
    end

    // Head is visible only once an edge has passed since it was written.
    function automatic bit exp_valid();
        return md.size() > 0 && me[0] < edge_n;
    endfunction

    task automatic drive(input bit pv, input logic [31:0] pd, input bit pr, input bit fl);
        pushValid = pv;
        pushData  = pd;
        popReady  = pr;
        flush     = fl;
    endtask

    task automatic tick();
        bit          do_push, do_pop, clr;
        logic [31:0] pd;
        do_push = pushValid && md.size() < 32;
        do_pop  = exp_valid() && popReady;
        clr     = reset || flush;
        pd      = pushData;
        @(posedge clock);
        edge_n++;
        if (clr) begin
            md.delete();
            me.delete();
            wr_n = 0;
            rd_n = 0;
        end else begin
            if (do_pop) begin
                void'(md.pop_front());
                void'(me.pop_front());
                rd_n++;
            end
            if (do_push) begin
                md.push_back(pd);
                me.push_back(edge_n);
                wr_n++;
            end
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        total++; if (popValid !== 1'b0) begin bad++; $display("FAIL reset_popValid: got %0b want 0", popValid); end
        total++; if (pushReady !== 1'b1) begin bad++; $display("FAIL reset_pushReady: got %0b want 1", pushReady); end
        total++; if (fillLevel !== 6'd0) begin bad++; $display("FAIL reset_fillLevel: got %0d want 0", fillLevel); end
        total++; if (almostFull !== 1'b0) begin bad++; $display("FAIL reset_almostFull: got %0b want 0", almostFull); end
        total++; if (memWriteEnable !== 1'b0) begin bad++; $display("FAIL reset_memWriteEnable: got %0b want 0", memWriteEnable); end
        tick();
    endtask

    task automatic test_single();
        drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        #1;
        total++; if (memWriteEnable !== 1'b1) begin bad++; $display("FAIL single_we: got %0b want 1", memWriteEnable); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        total++; if (popValid !== 1'b0) begin bad++; $display("FAIL single_valid_c1: got %0b want 0", popValid); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        total++; if (popValid !== 1'b1) begin bad++; $display("FAIL single_valid_c2: got %0b want 1", popValid); end
        total++; if (popData !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data: got %h want deadbeef", popData); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        total++; if (popValid !== 1'b0) begin bad++; $display("FAIL single_valid_c3: got %0b want 0", popValid); end
        total++; if (fillLevel !== 6'd0) begin bad++; $display("FAIL single_fill: got %0d want 0", fillLevel); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0);
            #1;
            total++; if (fillLevel !== 6'(i)) begin bad++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, fillLevel, i); end
            total++; if (almostFull !== (i >= 28)) begin bad++; $display("FAIL fill_af[%0d]: got %0b want %0b", i, almostFull, i >= 28); end
            total++; if (pushReady !== 1'b1) begin bad++; $display("FAIL fill_ready[%0d]: got %0b want 1", i, pushReady); end
            tick();
        end
        drive(1'b1, 32'd99, 1'b0, 1'b0);
        #1;
        total++; if (pushReady !== 1'b0) begin bad++; $display("FAIL full_ready: got %0b want 0", pushReady); end
        total++; if (memWriteEnable !== 1'b0) begin bad++; $display("FAIL full_we: got %0b want 0", memWriteEnable); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        total++; if (fillLevel !== 6'd32) begin bad++; $display("FAIL full_level: got %0d want 32", fillLevel); end
        for (int i = 0; i < 32; i++) begin
            total++; if (popValid !== 1'b1 || popData !== 32'(i)) begin
                bad++; $display("FAIL drain[%0d]: got v=%0b d=%0d want v=1 d=%0d", i, popValid, popData, i);
            end
            tick();
            #1;
        end
        total++; if (popValid !== 1'b0 || fillLevel !== 6'd0) begin
            bad++; $display("FAIL drain_end: got v=%0b fill=%0d want v=0 fill=0", popValid, fillLevel);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] nxt_in, nxt_out;
        nxt_in  = 32'h1000;
        nxt_out = 32'h1000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, nxt_in, 1'b0, 1'b0);
            nxt_in++;
            tick();
        end
        for (int i = 0; i < 53; i++) begin
            drive(i < 50, nxt_in, 1'b1, 1'b0);
            if (i < 50) nxt_in++;
            #1;
            total++; if (popValid !== 1'b1 || popData !== nxt_out) begin
                bad++; $display("FAIL wrap[%0d]: got v=%0b d=%h want v=1 d=%h", i, popValid, popData, nxt_out);
            end
            if (i < 50) begin
                total++; if (fillLevel !== 6'd3) begin bad++; $display("FAIL wrap_fill[%0d]: got %0d want 3", i, fillLevel); end
            end
            nxt_out++;
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_hazard();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h12345678, 1'b1, 1'b0);
        #1;
        total++; if (popValid !== 1'b1 || popData !== 32'h11) begin
            bad++; $display("FAIL hazard_pre: got v=%0b d=%h want v=1 d=00000011", popValid, popData);
        end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        total++; if (popValid !== 1'b0 || fillLevel !== 6'd1) begin
            bad++; $display("FAIL hazard_bubble: got v=%0b fill=%0d want v=0 fill=1", popValid, fillLevel);
        end
        tick();
        #1;
        total++; if (popValid !== 1'b1 || popData !== 32'h12345678 || fillLevel !== 6'd1) begin
            bad++; $display("FAIL hazard_post: got v=%0b d=%h fill=%0d want v=1 d=12345678 fill=1", popValid, popData, fillLevel);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'hFFFF, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        total++; if (fillLevel !== 6'd0 || popValid !== 1'b0) begin
            bad++; $display("FAIL flush_clear: got fill=%0d v=%0b want fill=0 v=0", fillLevel, popValid);
        end
        drive(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        #1;
        total++; if (popValid !== 1'b1 || popData !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL flush_first: got v=%0b d=%h want v=1 d=a5a5a5a5", popValid, popData);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int unsigned pv_pct = 50;
        int unsigned pr_pct = 50;
        bit          ev;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                pv_pct = $urandom_range(10, 100);
                pr_pct = $urandom_range(0, 100);
            end
            reset = ($urandom_range(0, 399) == 0);
            drive($urandom_range(0, 99) < pv_pct, $urandom, $urandom_range(0, 99) < pr_pct,
                  $urandom_range(0, 149) == 0);
            #1;
            ev = exp_valid();
            total++; if (pushReady !== (md.size() < 32)) begin
                bad++; $display("FAIL rnd_pushReady@%0d: got %0b want %0b", c, pushReady, md.size() < 32);
            end
            total++; if (popValid !== ev) begin
                bad++; $display("FAIL rnd_popValid@%0d: got %0b want %0b", c, popValid, ev);
            end
            if (ev) begin
                total++; if (popData !== md[0]) begin
                    bad++; $display("FAIL rnd_popData@%0d: got %h want %h", c, popData, md[0]);
                end
            end
            total++; if (fillLevel !== 6'(md.size()) || almostFull !== (md.size() >= 28)) begin
                bad++; $display("FAIL rnd_level@%0d: got fill=%0d af=%0b want fill=%0d af=%0b",
                                c, fillLevel, almostFull, md.size(), md.size() >= 28);
            end
            total++; if (memWriteEnable !== (pushValid && md.size() < 32) ||
                         memWriteAddress !== 5'(wr_n % 32)) begin
                bad++; $display("FAIL rnd_write@%0d: got we=%0b wa=%0d want we=%0b wa=%0d",
                                c, memWriteEnable, memWriteAddress, pushValid && md.size() < 32, wr_n % 32);
            end
            total++; if (memReadAddress !== 5'((rd_n + int'(ev && popReady)) % 32)) begin
                bad++; $display("FAIL rnd_readAddr@%0d: got %0d want %0d",
                                c, memReadAddress, (rd_n + int'(ev && popReady)) % 32);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        test_reset();
        test_single();
        test_fill_drain();
        test_wrap();
        test_hazard();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
